// File: rtl/v_hier_pkg.sv
// rtl/v_hier_pkg.sv - shared frame constants and FSM encoding for the serializer/deserializer pair
package v_hier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/v_hier_holdreg.sv
// rtl/v_hier_holdreg.sv - single-entry output holding register with valid/ready and overrun pulse
module v_hier_holdreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_overrun;

  // A word arriving while the consumer drains the old one replaces it without loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (!r_valid || i_ready) begin
          r_q     <= i_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_q       = r_q;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/v_hier_deser.sv
// rtl/v_hier_deser.sv - strobed serial-to-parallel deserializer with start/stop framing
module v_hier_deser
  import v_hier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             a_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_frame_err;
  logic             w_last_bit;
  logic             w_start;
  logic             w_shift_en;
  logic             w_complete;
  logic             w_bad_stop;

  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (a_valid) begin
      case (r_state)
        ST_IDLE: if (a == START_BIT) w_next_state = ST_DATA;
        ST_DATA: if (w_last_bit) w_next_state = ST_STOP;
        ST_STOP: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    w_complete = 1'b0;
    w_bad_stop = 1'b0;
    if (a_valid) begin
      case (r_state)
        ST_IDLE: w_start    = (a == START_BIT);
        ST_DATA: w_shift_en = 1'b1;
        ST_STOP: begin
          w_complete = (a == STOP_BIT);
          w_bad_stop = (a != STOP_BIT);
        end
        default: ;
      endcase
    end
  end

  // Bits land at their counter position, so the word is already LSB-first aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_bad_stop;
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (r_cnt == CW'(i)) r_shift[i] <= a;
        end
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  v_hier_holdreg #(
    .WIDTH(WIDTH)
  ) u_holdreg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_complete),
    .i_word   (r_shift),
    .i_ready  (q_ready),
    .o_q      (q),
    .o_valid  (q_valid),
    .o_overrun(overrun)
  );

  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_v_hier_deser.sv
// tb/tb_v_hier_deser.sv - self-checking bench for v_hier_deser with frame-level reference model
module tb_v_hier_deser;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             a;
  logic             a_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             frame_err;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  // Reference model state: expected outputs after the most recent edge
  bit               m_bits[$];
  logic [WIDTH-1:0] m_q     = '0;
  logic             m_valid = 1'b0;
  logic             m_ferr  = 1'b0;
  logic             m_ovr   = 1'b0;

  v_hier_deser #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .a_valid  (a_valid),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model advances on the same edge as the DUT (inputs are stable until the next negedge), then compares.
  always @(posedge clk) begin
    logic             complete;
    logic [WIDTH-1:0] word;
    #1;
    complete = 1'b0;
    word     = '0;
    if (reset) begin
      m_bits.delete();
      m_q = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (a_valid) begin
        if (m_bits.size() != 0 || a == 1'b1) m_bits.push_back(a);
        if (m_bits.size() == WIDTH + 2) begin
          for (int i = 0; i < WIDTH; i++) word[i] = m_bits[1 + i];
          if (m_bits[WIDTH + 1] == 1'b0) complete = 1'b1;
          else m_ferr = 1'b1;
          m_bits.delete();
        end
      end
      if (complete) begin
        if (!m_valid || q_ready) begin
          m_q = word;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && q_ready) begin
        m_valid = 1'b0;
      end
    end
    chk("model_q", q, m_q);
    chk("model_q_valid", q_valid, m_valid);
    chk("model_frame_err", frame_err, m_ferr);
    chk("model_overrun", overrun, m_ovr);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      a_valid = 1'b0;
      a = 1'($urandom);
      @(negedge clk);
    end
    a = b;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop, input int maxgap);
    send_bit(1'b1, $urandom_range(0, maxgap));
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], $urandom_range(0, maxgap));
    send_bit(stop, $urandom_range(0, maxgap));
  endtask

  initial begin
    int f0, o0;
    reset = 1'b1; a = 1'b0; a_valid = 1'b0; q_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_q", q, 0);
    chk("reset_q_valid", q_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back bits, one-cycle q_valid
    send_frame(8'hA5, 1'b0, 0);
    chk("b2b_q", q, 8'hA5);
    chk("b2b_q_valid", q_valid, 1);
    chk("b2b_model_pin", m_q, 8'hA5);
    @(negedge clk);
    chk("b2b_q_valid_drop", q_valid, 0);

    // Random gaps with noise on a between strobes
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b0, 5);
    chk("gap_q", q, 8'hA5);
    chk("gap_q_valid", q_valid, 1);
    @(negedge clk);
    chk("gap_no_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Bad stop bit then recovery
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1, 1);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_q_valid", q_valid, 0);
    @(negedge clk);
    chk("ferr_pulse_end", frame_err, 0);
    chk("ferr_count", ferr_cnt - f0, 1);
    send_frame(8'h11, 1'b0, 2);
    chk("recover_q", q, 8'h11);
    chk("recover_q_valid", q_valid, 1);
    @(negedge clk);

    // Overrun with consumer stalled, then drain
    q_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h01, 1'b0, 1);
    chk("stall_first_q", q, 8'h01);
    send_frame(8'h02, 1'b0, 1);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_q_held", q, 8'h01);
    chk("ovr_q_valid", q_valid, 1);
    @(negedge clk);
    chk("ovr_pulse_end", overrun, 0);
    chk("ovr_count", ovr_cnt - o0, 1);
    q_ready = 1'b1;
    @(negedge clk);
    chk("drain_q_valid", q_valid, 0);
    chk("drain_q_last", q, 8'h01);

    // Drain on the exact stop-bit edge of the next frame
    q_ready = 1'b0;
    send_frame(8'h01, 1'b0, 0);
    chk("sim_first_q", q, 8'h01);
    send_bit(1'b1, 1);
    for (int i = 0; i < WIDTH; i++) send_bit(i == 1, 0);
    q_ready = 1'b1;
    send_bit(1'b0, 0);
    chk("sim_q", q, 8'h02);
    chk("sim_q_valid", q_valid, 1);
    chk("sim_overrun", overrun, 0);
    @(negedge clk);
    chk("sim_drain", q_valid, 0);

    // Reset mid-frame, with a strobe asserted during reset
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    reset = 1'b1; a = 1'b1; a_valid = 1'b1;
    @(negedge clk);
    chk("midrst_q", q, 0);
    chk("midrst_q_valid", q_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun", overrun, 0);
    reset = 1'b0; a_valid = 1'b0; a = 1'b0;
    @(negedge clk);
    send_frame(8'h7E, 1'b0, 1);
    chk("postrst_q", q, 8'h7E);
    chk("postrst_q_valid", q_valid, 1);
    chk("postrst_no_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v_hier_deser.md
V_HIER_DESER -- requirements
Module: v_hier_deser

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: a  input  1  serial data bit; sampled only when a_valid=1.
REQ-005 Port: a_valid  input  1  bit strobe qualifying a.
REQ-006 Port: q  output  WIDTH  deserialized word from the output holding register.
REQ-007 Port: q_valid  output  1  holding register contains an unread word.
REQ-008 Port: q_ready  input  1  consumer accepts q when q_valid=1 and q_ready=1.
REQ-009 Port: frame_err  output  1  one-cycle pulse; bad stop bit detected.
REQ-010 Port: overrun  output  1  one-cycle pulse; completed word dropped because the holding register was full.

Function
REQ-011 Frame format on strobed bits: start bit a=1, then WIDTH data bits LSB first, then stop bit a=0.
REQ-012 The FSM SHALL have states IDLE, DATA, STOP; it advances only on cycles with a_valid=1.
REQ-013 IDLE: a_valid & a=1 -> DATA with bit counter=0; a_valid & a=0 -> stay IDLE (line idle, no error).
REQ-014 DATA: each a_valid shifts a into shift-register bit position [counter]; the counter increments; after bit WIDTH-1 -> STOP.
REQ-015 Bit counter width: $clog2(WIDTH+1); no wrap-around within a frame.
REQ-016 STOP: a_valid & a=0 -> word complete, -> IDLE; a_valid & a=1 -> frame_err pulse next cycle, word discarded, -> IDLE.
REQ-017 Latency: q and q_valid update on the clock edge that samples a good stop bit, so they are visible in the following cycle.
REQ-018 Handshake: q_valid & q_ready on an edge -> q_valid clears, unless a word completes on the same edge.
REQ-019 Simultaneous complete and drain: the new word loads, q_valid stays 1, and overrun stays 0.
REQ-020 Complete with q_valid=1 & q_ready=0: the new word is dropped, q is unchanged, and overrun pulses for one cycle.
REQ-021 q SHALL hold stable while q_valid=1 and no transfer occurs.
REQ-022 a_valid=0 cycles SHALL be ignored in every state; gaps of any length are legal mid-frame.
REQ-023 frame_err and overrun SHALL never assert in the same cycle, and neither asserts for longer than one cycle per event.

Reset
REQ-024 While reset=1: state=IDLE, counter=0, shift register=0, q=0, q_valid=0, frame_err=0, overrun=0.
REQ-025 Reset mid-frame SHALL abandon the partial word without any error pulse; the next start bit after reset begins a fresh frame.
REQ-026 Reset has priority over a_valid and q_ready in the same cycle.

Structure
REQ-027 State encodings (IDLE=2'd0, DATA=2'd1, STOP=2'd2) and the start/stop bit polarity constants SHALL reside in a shared package v_hier_pkg, reused by the matching serializer.
REQ-028 The output holding register and its valid/ready logic SHALL be a sub-module v_hier_holdreg (parameter WIDTH); the FSM and shift register stay in the top module.

Verification
REQ-029 WIDTH=8, q_ready=1; bits 1, 0xA5 LSB first, 0 on consecutive a_valid cycles -> q=8'hA5 and q_valid=1 for exactly one cycle, starting the cycle after the stop bit.
REQ-030 Same frame with random a_valid gaps (0-5 idle cycles between bits) -> q=8'hA5 and no error pulses.
REQ-031 Frame 0x3C with stop bit=1 -> frame_err is a single pulse, q_valid stays 0, and the next good frame 0x11 delivers q=8'h11.
REQ-032 q_ready=0; frames 0x01 then 0x02 -> q=8'h01 held, overrun pulses once after the second stop bit; raising q_ready then drains 0x01 and q_valid goes to 0.
REQ-033 q_valid=1 holding 0x01 with q_ready=1 on exactly the stop-bit edge of frame 0x02 -> q=8'h02, q_valid stays 1, overrun=0.
REQ-034 reset pulsed after 4 data bits of a frame -> all outputs 0 and no pulses; the following full frame 0x7E yields q=8'h7E.
